// File: rtl/cache_refill_ctrl.sv
// Miss-handling engine for the unified cache.
// On a miss it optionally writes the dirty victim line back to byte-wide
// main memory, then refills the missing 64-byte line one byte at a time,
// streaming each returned byte straight into the cache data array.
//
// Memory handshake: mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o are decoded
// from registered state only, so they hold steady until mem_ack_i; a byte
// transfers on any cycle where mem_req_o && mem_ack_i (including the first
// cycle of a request). mem_ack_i has no effect while mem_req_o is low.
// Miss handshake: a miss is taken on a cycle with miss_valid_i && miss_ready_o.
module cache_refill_ctrl #(
  parameter int ADDR_W = 32,
  parameter int OFF_W  = 6,
  parameter int IDX_W  = 6,
  parameter int TAG_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_valid_i,
  output logic              miss_ready_o,
  input  logic [ADDR_W-1:0] miss_addr_i,
  input  logic              miss_who_i,
  input  logic              wb_dirty_i,
  input  logic [TAG_W-1:0]  wb_tag_i,
  output logic [OFF_W-1:0]  wb_rd_off_o,
  input  logic [7:0]        wb_data_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [7:0]        mem_rdata_i,
  output logic              fill_we_o,
  output logic [OFF_W-1:0]  fill_off_o,
  output logic [7:0]        fill_data_o,
  output logic              done_o,
  output logic              done_who_o,
  output logic              busy_o
);

  localparam int LINE_W = ADDR_W - OFF_W;
  localparam logic [OFF_W-1:0] OFF_ONE  = OFF_W'(1);
  localparam logic [OFF_W-1:0] OFF_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [OFF_W-1:0]  off_q,   off_d;
  logic [LINE_W-1:0] line_q,  line_d;
  logic              who_q,   who_d;
  logic [TAG_W-1:0]  vtag_q,  vtag_d;

  // The line offset bits of the miss address carry no information here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^miss_addr_i[OFF_W-1:0];

  // Next-state and capture logic. The dirty flag only steers the first
  // transition, so it is consumed at acceptance rather than stored.
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    line_d  = line_q;
    who_d   = who_q;
    vtag_d  = vtag_q;
    case (state_q)
      S_IDLE: begin
        if (miss_valid_i) begin
          line_d  = miss_addr_i[ADDR_W-1:OFF_W];
          who_d   = miss_who_i;
          vtag_d  = wb_tag_i;
          off_d   = '0;
          state_d = wb_dirty_i ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        if (mem_ack_i) begin
          off_d = off_q + OFF_ONE;
          if (off_q == OFF_LAST) begin
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (mem_ack_i) begin
          off_d = off_q + OFF_ONE;
          if (off_q == OFF_LAST) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any line in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      off_q   <= '0;
      line_q  <= '0;
      who_q   <= 1'b0;
      vtag_q  <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      line_q  <= line_d;
      who_q   <= who_d;
      vtag_q  <= vtag_d;
    end
  end

  // Output decode from registered state; fill strobe follows the read ack
  // in the same cycle and is suppressed while reset is being applied.
  always_comb begin
    miss_ready_o = (state_q == S_IDLE);
    busy_o       = (state_q != S_IDLE);
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    wb_rd_off_o  = '0;
    fill_we_o    = 1'b0;
    fill_off_o   = '0;
    fill_data_o  = '0;
    done_o       = 1'b0;
    done_who_o   = 1'b0;
    case (state_q)
      S_WB: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {vtag_q, line_q[IDX_W-1:0], off_q};
        wb_rd_off_o = off_q;
        mem_wdata_o = wb_data_i;
      end
      S_FILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {line_q, off_q};
        if (mem_ack_i && !rst) begin
          fill_we_o   = 1'b1;
          fill_off_o  = off_q;
          fill_data_o = mem_rdata_i;
        end
      end
      S_DONE: begin
        done_o     = 1'b1;
        done_who_o = who_q;
      end
      default: begin
      end
    endcase
  end

  // Request bus holds its address and direction until the byte is acked.
  a_req_hold: assert property (@(posedge clk) disable iff (rst)
    (mem_req_o && !mem_ack_i) |=> (mem_req_o && $stable(mem_addr_o) && $stable(mem_we_o)));

  // Cache writes only happen on an acked refill byte.
  a_fill_on_ack: assert property (@(posedge clk)
    fill_we_o |-> (state_q == S_FILL && mem_ack_i));

  // Completion is a single-cycle pulse.
  a_done_pulse: assert property (@(posedge clk) disable iff (rst)
    done_o |=> !done_o);

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: a byte-addressed memory model with a
// selectable ack pattern, a victim line array acting as the cache read
// port, and a scoreboard of expected memory transfers, fill writes and
// completions built from the line-level behaviour of a miss.
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_valid_i = 1'b0;
  logic        miss_ready_o;
  logic [31:0] miss_addr_i = '0;
  logic        miss_who_i = 1'b0;
  logic        wb_dirty_i = 1'b0;
  logic [19:0] wb_tag_i = '0;
  logic [5:0]  wb_rd_off_o;
  logic [7:0]  wb_data_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [7:0]  mem_rdata_i;
  logic        fill_we_o;
  logic [5:0]  fill_off_o;
  logic [7:0]  fill_data_o;
  logic        done_o;
  logic        done_who_o;
  logic        busy_o;

  cache_refill_ctrl dut (
    .clk(clk), .rst(rst),
    .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
    .miss_addr_i(miss_addr_i), .miss_who_i(miss_who_i),
    .wb_dirty_i(wb_dirty_i), .wb_tag_i(wb_tag_i),
    .wb_rd_off_o(wb_rd_off_o), .wb_data_i(wb_data_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .fill_we_o(fill_we_o), .fill_off_o(fill_off_o), .fill_data_o(fill_data_o),
    .done_o(done_o), .done_who_o(done_who_o), .busy_o(busy_o)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- models ----------------
  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int fill_cnt = 0;
  int last_done_cyc = 0;
  int acc_cyc = 0;
  int ack_mode = 3;  // 0: always, 1: every 3rd request cycle, 2: random, 3: off
  int wait_cnt = 0;

  logic [40:0] exp_mem_q[$];   // {we, addr, wdata (0 for reads)}
  logic [13:0] exp_fill_q[$];  // {off, data}
  logic [0:0]  exp_done_q[$];  // who

  logic [7:0] victim [64];

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
  endfunction

  assign wb_data_i   = victim[wb_rd_off_o];
  assign mem_rdata_i = mem_ack_i ? mem_byte(mem_addr_o) : 8'h00;

  // Memory ack generator, updated shortly after each rising edge.
  initial forever begin
    @(posedge clk);
    #2;
    case (ack_mode)
      0: mem_ack_i = 1'b1;
      1: begin
        if (mem_req_o) begin
          mem_ack_i = (wait_cnt == 2);
          wait_cnt  = (wait_cnt == 2) ? 0 : wait_cnt + 1;
        end else begin
          mem_ack_i = 1'b0;
          wait_cnt  = 0;
        end
      end
      2: mem_ack_i = 1'($urandom_range(0, 1));
      default: mem_ack_i = 1'b0;
    endcase
  end

  // ---------------- scoreboard (samples on falling edge) ----------------
  initial begin
    logic [40:0] e_mem;
    logic [13:0] e_fill;
    logic [0:0]  e_who;
    logic [40:0] act;
    logic        prev_wait;
    logic [40:0] prev_bus;
    prev_wait = 1'b0;
    prev_bus  = '0;
    forever begin
      @(negedge clk);
      if (prev_wait && mem_req_o) begin
        n_cmp++;
        if ({mem_we_o, mem_addr_o, mem_wdata_o} !== prev_bus) begin
          n_err++;
          $display("FAIL bus_hold: got %h required %h", {mem_we_o, mem_addr_o, mem_wdata_o}, prev_bus);
        end
      end
      prev_wait = (mem_req_o === 1'b1) && (mem_ack_i === 1'b0);
      prev_bus  = {mem_we_o, mem_addr_o, mem_wdata_o};
      if (mem_req_o === 1'b1 && mem_ack_i === 1'b1) begin
        act = {mem_we_o, mem_addr_o, (mem_we_o ? mem_wdata_o : 8'h00)};
        n_cmp++;
        if (exp_mem_q.size() == 0) begin
          n_err++;
          $display("FAIL mem_txn: unexpected transfer %h, none required", act);
        end else begin
          e_mem = exp_mem_q.pop_front();
          if (act !== e_mem) begin
            n_err++;
            $display("FAIL mem_txn: got %h required %h", act, e_mem);
          end
        end
      end
      if (fill_we_o === 1'b1) begin
        fill_cnt++;
        n_cmp++;
        if (exp_fill_q.size() == 0) begin
          n_err++;
          $display("FAIL fill: unexpected write off %0d data %h", fill_off_o, fill_data_o);
        end else begin
          e_fill = exp_fill_q.pop_front();
          if ({fill_off_o, fill_data_o} !== e_fill) begin
            n_err++;
            $display("FAIL fill: got %h required %h", {fill_off_o, fill_data_o}, e_fill);
          end
        end
      end
      if (done_o === 1'b1) begin
        done_cnt++;
        last_done_cyc = cyc;
        n_cmp++;
        if (exp_done_q.size() == 0) begin
          n_err++;
          $display("FAIL done: unexpected done_o who=%0d", done_who_o);
        end else begin
          e_who = exp_done_q.pop_front();
          if (done_who_o !== e_who[0]) begin
            n_err++;
            $display("FAIL done_who: got %0d required %0d", done_who_o, e_who[0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic randomize_victim();
    for (int i = 0; i < 64; i++) victim[i] = 8'($urandom);
  endtask

  task automatic push_miss(input logic [31:0] a, input logic w, input logic d,
                           input logic [19:0] t);
    logic [31:0] wb_base;
    logic [31:0] rd_base;
    wb_base = ({12'h000, t} << 12) | (a & 32'h0000_0FC0);
    rd_base = a & 32'hFFFF_FFC0;
    if (d) begin
      for (int i = 0; i < 64; i++) exp_mem_q.push_back({1'b1, wb_base + 32'(i), victim[i]});
    end
    for (int i = 0; i < 64; i++) begin
      exp_mem_q.push_back({1'b0, rd_base + 32'(i), 8'h00});
      exp_fill_q.push_back({6'(i), mem_byte(rd_base + 32'(i))});
    end
    exp_done_q.push_back(w);
  endtask

  // Present a miss, hold it until taken, then scramble the miss-side inputs.
  task automatic issue_miss(input logic [31:0] a, input logic w, input logic d,
                            input logic [19:0] t);
    int n;
    push_miss(a, w, d, t);
    miss_valid_i = 1'b1;
    miss_addr_i  = a;
    miss_who_i   = w;
    wb_dirty_i   = d;
    wb_tag_i     = t;
    n = 0;
    while (miss_ready_o !== 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (miss_ready_o !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: miss_ready_o=%b after %0d cycles, required 1", miss_ready_o, n);
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    miss_valid_i = 1'b0;
    miss_addr_i  = $urandom;
    wb_dirty_i   = 1'($urandom_range(0, 1));
    wb_tag_i     = 20'($urandom);
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if (done_cnt < target) begin
      n_err++;
      $display("FAIL done_timeout: done count %0d required %0d", done_cnt, target);
    end
    n_cmp++;
    if (exp_mem_q.size() != 0 || exp_fill_q.size() != 0 || exp_done_q.size() != 0) begin
      n_err++;
      $display("FAIL drained: pending mem=%0d fill=%0d done=%0d required 0/0/0",
               exp_mem_q.size(), exp_fill_q.size(), exp_done_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({miss_ready_o, busy_o, done_o, done_who_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
         fill_we_o, fill_off_o, fill_data_o, wb_rd_off_o} !== {1'b1, 66'd0}) begin
      n_err++;
      $display("FAIL reset_outputs: ready=%b busy=%b req=%b addr=%h fill_we=%b done=%b, required ready=1 rest 0",
               miss_ready_o, busy_o, mem_req_o, mem_addr_o, fill_we_o, done_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (miss_ready_o !== 1'b1 || busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: ready=%b busy=%b req=%b required 1/0/0", miss_ready_o, busy_o, mem_req_o);
    end
  endtask

  task automatic test_clean_miss();
    int base_d, base_f;
    ack_mode = 0;
    base_d = done_cnt; base_f = fill_cnt;
    issue_miss(32'h0000_1234, 1'b1, 1'b0, 20'($urandom));
    wait_done(base_d + 1);
    n_cmp++;
    if (last_done_cyc - acc_cyc != 65) begin
      n_err++;
      $display("FAIL clean_latency: done at cycle %0d required 65", last_done_cyc - acc_cyc);
    end
    n_cmp++;
    if (miss_ready_o !== 1'b1 || cyc - acc_cyc != 66) begin
      n_err++;
      $display("FAIL clean_ready_back: ready=%b at cycle %0d required 1 at 66", miss_ready_o, cyc - acc_cyc);
    end
    n_cmp++;
    if (fill_cnt - base_f != 64) begin
      n_err++;
      $display("FAIL clean_fill_count: got %0d required 64", fill_cnt - base_f);
    end
  endtask

  task automatic test_dirty_miss();
    int base_d;
    ack_mode = 0;
    randomize_victim();
    base_d = done_cnt;
    issue_miss(32'h0004_0080, 1'($urandom_range(0, 1)), 1'b1, 20'h00ABC);
    wait_done(base_d + 1);
    n_cmp++;
    if (last_done_cyc - acc_cyc != 129) begin
      n_err++;
      $display("FAIL dirty_latency: done at cycle %0d required 129", last_done_cyc - acc_cyc);
    end
  endtask

  task automatic test_wait_states();
    int base_d, base_f;
    ack_mode = 1;
    base_d = done_cnt; base_f = fill_cnt;
    issue_miss($urandom, 1'b0, 1'b0, 20'($urandom));
    wait_done(base_d + 1);
    n_cmp++;
    if (last_done_cyc - acc_cyc != 193) begin
      n_err++;
      $display("FAIL wait_latency: done at cycle %0d required 193", last_done_cyc - acc_cyc);
    end
    n_cmp++;
    if (fill_cnt - base_f != 64) begin
      n_err++;
      $display("FAIL wait_fill_count: got %0d required 64", fill_cnt - base_f);
    end
  endtask

  task automatic test_back_to_back();
    int base_d, n;
    logic [31:0] a2;
    logic w2, d2;
    logic [19:0] t2;
    ack_mode = 2;
    randomize_victim();
    base_d = done_cnt;
    a2 = $urandom; w2 = 1'($urandom_range(0, 1)); d2 = 1'($urandom_range(0, 1)); t2 = 20'($urandom);
    miss_addr_i = $urandom | 32'h0000_0040;  // different line from a2 in general
    miss_who_i  = ~w2;
    wb_dirty_i  = 1'($urandom_range(0, 1));
    wb_tag_i    = 20'($urandom);
    push_miss(miss_addr_i, miss_who_i, wb_dirty_i, wb_tag_i);
    push_miss(a2, w2, d2, t2);
    miss_valid_i = 1'b1;
    @(posedge clk); #1;
    miss_addr_i = a2; miss_who_i = w2; wb_dirty_i = d2; wb_tag_i = t2;
    n = 0;
    while (done_cnt == base_d && n < 3000) begin
      n_cmp++;
      if (miss_ready_o !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_ready_busy: miss_ready_o=%b while first miss in flight, required 0", miss_ready_o);
      end
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if (miss_ready_o !== 1'b1 || cyc != last_done_cyc + 1) begin
      n_err++;
      $display("FAIL b2b_second_accept: ready=%b at cycle %0d, required 1 at %0d", miss_ready_o, cyc, last_done_cyc + 1);
    end
    @(posedge clk); #1;
    miss_valid_i = 1'b0;
    wait_done(base_d + 2);
  endtask

  task automatic test_random();
    int base_d;
    ack_mode = 2;
    randomize_victim();
    base_d = done_cnt;
    for (int k = 0; k < 6; k++) begin
      issue_miss($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 20'($urandom));
    end
    wait_done(base_d + 6);
  endtask

  task automatic test_reset_mid_fill();
    int base_d, base_f, n;
    ack_mode = 0;
    base_d = done_cnt; base_f = fill_cnt;
    issue_miss($urandom, 1'b1, 1'b0, 20'($urandom));
    n = 0;
    while (fill_cnt - base_f < 10 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if (fill_off_o !== 6'd10) begin
      n_err++;
      $display("FAIL mid_fill_offset: got %0d required 10", fill_off_o);
    end
    rst = 1'b1;
    ack_mode = 3;
    exp_mem_q.delete(); exp_fill_q.delete(); exp_done_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({miss_ready_o, busy_o, done_o, done_who_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
         fill_we_o, fill_off_o, fill_data_o, wb_rd_off_o} !== {1'b1, 66'd0}) begin
      n_err++;
      $display("FAIL mid_reset_idle: ready=%b busy=%b req=%b addr=%h fill_we=%b done=%b, required ready=1 rest 0",
               miss_ready_o, busy_o, mem_req_o, mem_addr_o, fill_we_o, done_o);
    end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (done_cnt != base_d || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_quiet: done count %0d busy=%b, required %0d and 0", done_cnt, busy_o, base_d);
    end
    ack_mode = 0;
    issue_miss($urandom, 1'b0, 1'b0, 20'($urandom));
    wait_done(base_d + 1);
  endtask

  task automatic test_reset_with_miss();
    ack_mode = 0;
    rst = 1'b1;
    miss_valid_i = 1'b1;
    miss_addr_i  = $urandom;
    wb_dirty_i   = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    rst = 1'b0;
    miss_valid_i = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b0 || miss_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_with_miss: busy=%b ready=%b required 0/1", busy_o, miss_ready_o);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_with_miss_later: busy=%b req=%b required 0/0", busy_o, mem_req_o);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    randomize_victim();
    @(posedge clk); #1;
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_wait_states();
    test_back_to_back();
    test_random();
    test_reset_mid_fill();
    test_reset_with_miss();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
